// File: rtl/serial_frame_rx.sv
// serial_frame_rx: hunts a serial bitstream for a sync pattern, then
// deserialises a DATA_W-bit payload (MSB first) and one parity bit, and
// presents the word with a one-cycle valid strobe, parity flag and frame count.
module serial_frame_rx #(
  parameter int                DATA_W     = 8,
  parameter int                SYNC_W     = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT   = 4'b1011,
  parameter int                PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si,
  input  logic              bit_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              parity_err,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int FW = $clog2(SYNC_W + 1);
  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [FW-1:0] FILL_FULL = FW'(SYNC_W);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DATA_W - 1);

  typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

  state_t            state, state_nxt;
  logic [SYNC_W-1:0] win;
  logic [SYNC_W-1:0] win_upd;
  logic [FW-1:0]     fill;
  logic [FW-1:0]     fill_upd;
  logic [CW-1:0]     bcnt;
  logic [DATA_W-1:0] shreg;
  logic              match;
  logic              frame_done;

  // Parity verdict over payload plus received parity bit; 1 means error.
  function automatic logic parity_bad(input logic [DATA_W-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    return (PARITY_ODD != 0) ? ~x : x;
  endfunction

  // Next-state logic; sync match requires a fully filled window so a
  // reset-cleared window can never match a pattern with leading zeros.
  always_comb begin
    state_nxt  = state;
    win_upd    = {win[SYNC_W-2:0], si};
    fill_upd   = (fill == FILL_FULL) ? fill : fill + FW'(1);
    match      = 1'b0;
    frame_done = 1'b0;
    if (bit_en) begin
      case (state)
        HUNT: begin
          match = (fill_upd == FILL_FULL) && (win_upd == SYNC_PAT);
          if (match) state_nxt = DATA;
        end
        DATA: begin
          if (bcnt == CNT_LAST) state_nxt = PARITY;
        end
        PARITY: begin
          frame_done = 1'b1;
          state_nxt  = HUNT;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // State register; busy is registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != HUNT);
    end
  end

  // Sync window and fill count: slide in HUNT, clear at end of frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      win  <= '0;
      fill <= '0;
    end else if (frame_done) begin
      win  <= '0;
      fill <= '0;
    end else if (bit_en && state == HUNT) begin
      win  <= win_upd;
      fill <= fill_upd;
    end
  end

  // Payload bit counter (control, reset) and shift register (data path).
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt <= '0;
    end else if (match) begin
      bcnt <= '0;
    end else if (bit_en && state == DATA) begin
      bcnt <= bcnt + CW'(1);
    end
  end

  // Payload shift register, cleared when sync is found.
  always_ff @(posedge clk) begin
    if (match) begin
      shreg <= '0;
    end else if (bit_en && state == DATA) begin
      shreg <= {shreg[DATA_W-2:0], si};
    end
  end

  // Output registers: word, parity flag and count update on the parity edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      dout_valid <= frame_done;
      if (frame_done) begin
        dout       <= shreg;
        parity_err <= parity_bad(shreg, si);
        frame_cnt  <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: scenario tasks drive bit streams, a scoreboard
// queue holds the expected word/flag/count for each frame and a negedge
// monitor compares every dout_valid pulse against it.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       si;
  logic       bit_en;
  logic [7:0] dout, dout_o;
  logic       dout_valid, dout_valid_o;
  logic       parity_err, parity_err_o;
  logic       busy, busy_o;
  logic [7:0] frame_cnt, frame_cnt_o;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_pass  = 0;
  int         n_total = 0;
  int         n_valid = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b1011), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .si(si), .bit_en(bit_en),
    .dout(dout), .dout_valid(dout_valid), .parity_err(parity_err),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  serial_frame_rx #(.DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b1011), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .si(si), .bit_en(bit_en),
    .dout(dout_o), .dout_valid(dout_valid_o), .parity_err(parity_err_o),
    .busy(busy_o), .frame_cnt(frame_cnt_o)
  );

  // Scoreboard monitor: every valid pulse must be single-cycle and expected.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      n_valid++;
      n_total++;
      if (prev_valid === 1'b1)
        $display("FAIL valid_width: dout_valid high %0d cycles in a row, required 1", 2);
      else
        n_pass++;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid: dout=%h perr=%b cnt=%0d, required no pulse",
                 dout, parity_err, frame_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({dout, parity_err, frame_cnt} !== e)
          $display("FAIL frame: dout=%h perr=%b cnt=%0d, required dout=%h perr=%b cnt=%0d",
                   dout, parity_err, frame_cnt, e.d, e.pe, e.cnt);
        else
          n_pass++;
      end
    end
    prev_valid = dout_valid;
  end

  task automatic bit_cycle(input logic b, input logic en);
    si     = b;
    bit_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    si     = 1'($urandom);
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    bit_en = 1'b0;
    exp_cnt = 8'd0;
  endtask

  // Qualified bit, optionally followed by one bit_en=0 cycle of garbage.
  task automatic qbit(input logic b, input bit gaps);
    bit_cycle(b, 1'b1);
    if (gaps) bit_cycle(1'($urandom), 1'b0);
  endtask

  // Sync 1011, payload MSB first, parity bit; expectation pushed with p.
  task automatic send_frame(input logic [7:0] d, input logic p, input bit gaps);
    logic [3:0] sp;
    exp_t e;
    sp = 4'b1011;
    for (int i = 3; i >= 0; i--) qbit(sp[i], gaps);
    for (int i = 7; i >= 0; i--) qbit(d[i], gaps);
    exp_cnt = exp_cnt + 8'd1;
    e.d   = d;
    e.pe  = (^d) ^ p;
    e.cnt = exp_cnt;
    sb.push_back(e);
    bit_cycle(p, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({dout, dout_valid, parity_err, busy, frame_cnt} !== 20'd0)
      $display("FAIL reset_state: dout=%h v=%b pe=%b busy=%b cnt=%0d, required all 0",
               dout, dout_valid, parity_err, busy, frame_cnt);
    else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    send_frame(8'hA5, 1'b0, 1'b0);
    n_total++;
    if ({dout_valid, dout, parity_err, frame_cnt, busy} !== {1'b1, 8'hA5, 1'b0, 8'd1, 1'b0})
      $display("FAIL basic_frame: v=%b dout=%h pe=%b cnt=%0d busy=%b, required v=1 dout=a5 pe=0 cnt=1 busy=0",
               dout_valid, dout, parity_err, frame_cnt, busy);
    else n_pass++;
    bit_cycle(1'b1, 1'b0);
    n_total++;
    if (dout_valid !== 1'b0 || dout !== 8'hA5)
      $display("FAIL basic_hold: v=%b dout=%h, required v=0 dout=a5", dout_valid, dout);
    else n_pass++;
  endtask

  task automatic test_parity();
    do_reset();
    send_frame(8'hA5, 1'b1, 1'b0);
    n_total++;
    if ({dout_valid, dout, parity_err, frame_cnt} !== {1'b1, 8'hA5, 1'b1, 8'd1})
      $display("FAIL parity_even_err: v=%b dout=%h pe=%b cnt=%0d, required v=1 dout=a5 pe=1 cnt=1",
               dout_valid, dout, parity_err, frame_cnt);
    else n_pass++;
    n_total++;
    if ({dout_valid_o, dout_o, parity_err_o} !== {1'b1, 8'hA5, 1'b0})
      $display("FAIL parity_odd_ok: v=%b dout=%h pe=%b, required v=1 dout=a5 pe=0",
               dout_valid_o, dout_o, parity_err_o);
    else n_pass++;
    send_frame(8'h5A, 1'b0, 1'b0);
    n_total++;
    if (parity_err_o !== 1'b1 || parity_err !== 1'b0)
      $display("FAIL parity_odd_err: odd pe=%b even pe=%b, required odd 1 even 0",
               parity_err_o, parity_err);
    else n_pass++;
  endtask

  task automatic test_sliding();
    logic [5:0] pre;
    logic [7:0] d;
    exp_t e;
    int   v0;
    do_reset();
    v0  = n_valid;
    pre = 6'b101011;
    d   = 8'hBB;
    for (int i = 5; i >= 0; i--) bit_cycle(pre[i], 1'b1);
    for (int i = 7; i >= 0; i--) begin
      n_total++;
      if (busy !== 1'b1) $display("FAIL sliding_busy: busy=%b before payload bit %0d, required 1", busy, 7 - i);
      else n_pass++;
      bit_cycle(d[i], 1'b1);
    end
    n_total++;
    if (busy !== 1'b1) $display("FAIL sliding_busy_p: busy=%b before parity bit, required 1", busy);
    else n_pass++;
    exp_cnt = exp_cnt + 8'd1;
    e.d = 8'hBB; e.pe = 1'b0; e.cnt = exp_cnt;
    sb.push_back(e);
    bit_cycle(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) bit_cycle(1'b0, 1'b1);
    n_total++;
    if (n_valid - v0 !== 1 || dout !== 8'hBB || busy !== 1'b0)
      $display("FAIL sliding_frames: pulses=%0d dout=%h busy=%b, required 1 bb 0", n_valid - v0, dout, busy);
    else n_pass++;
  endtask

  task automatic test_gaps();
    int v0;
    do_reset();
    v0 = n_valid;
    send_frame(8'hA5, 1'b0, 1'b1);
    n_total++;
    if ({dout_valid, dout, parity_err, frame_cnt} !== {1'b1, 8'hA5, 1'b0, 8'd1})
      $display("FAIL gaps_frame: v=%b dout=%h pe=%b cnt=%0d, required v=1 dout=a5 pe=0 cnt=1",
               dout_valid, dout, parity_err, frame_cnt);
    else n_pass++;
    bit_cycle(1'($urandom), 1'b0);
    bit_cycle(1'($urandom), 1'b0);
    n_total++;
    if (dout_valid !== 1'b0 || n_valid - v0 !== 1)
      $display("FAIL gaps_pulse: v=%b pulses=%0d, required v=0 pulses=1", dout_valid, n_valid - v0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] sp;
    do_reset();
    sp = 4'b1011;
    for (int i = 3; i >= 0; i--) bit_cycle(sp[i], 1'b1);
    bit_cycle(1'b0, 1'b1);
    bit_cycle(1'b0, 1'b1);
    bit_cycle(1'b1, 1'b1);
    do_reset();
    n_total++;
    if ({busy, dout, frame_cnt, dout_valid} !== 18'd0)
      $display("FAIL reset_mid: busy=%b dout=%h cnt=%0d v=%b, required all 0",
               busy, dout, frame_cnt, dout_valid);
    else n_pass++;
    send_frame(8'h3C, 1'b0, 1'b0);
    n_total++;
    if ({dout_valid, dout, parity_err, frame_cnt} !== {1'b1, 8'h3C, 1'b0, 8'd1})
      $display("FAIL reset_mid_next: v=%b dout=%h pe=%b cnt=%0d, required v=1 dout=3c pe=0 cnt=1",
               dout_valid, dout, parity_err, frame_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int v0;
    do_reset();
    v0 = n_valid;
    for (int f = 0; f < 256; f++)
      send_frame(8'($urandom), 1'($urandom), 1'b0);
    bit_cycle(1'b0, 1'b0);
    n_total++;
    if (frame_cnt !== 8'd0 || n_valid - v0 !== 256)
      $display("FAIL wrap: cnt=%0d pulses=%0d, required cnt=0 pulses=256", frame_cnt, n_valid - v0);
    else n_pass++;
    send_frame(8'h81, 1'b0, 1'b0);
    n_total++;
    if (frame_cnt !== 8'd1 || dout !== 8'h81)
      $display("FAIL wrap_next: cnt=%0d dout=%h, required cnt=1 dout=81", frame_cnt, dout);
    else n_pass++;
    bit_cycle(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; si = 1'b0; bit_en = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_parity();
    test_sliding();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    repeat (3) bit_cycle(1'b0, 1'b0);
    n_total++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d frames never seen, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Downstream consumer of the serial bitstream produced by the SISO shift-register stage. Hunts the incoming bit stream for a fixed sync pattern. Then deserialises a DATA_W-bit payload (MSB first) plus one parity bit, and presents the word in parallel with a one-cycle valid strobe, a parity-error flag and a running frame count.

Parameters:
DATA_W, 8, payload width in bits
SYNC_W, 4, sync pattern width in bits
SYNC_PAT, 4'b1011, sync pattern; first-received bit is the MSB
PARITY_ODD, 0, 0 = even parity over payload+parity bit, 1 = odd

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
si  input  1  serial bit from upstream shift register (so of previous stage)
bit_en  input  1  qualifies si; bit sampled only on edges where bit_en=1
dout  output  DATA_W  last received payload, MSB = first payload bit
dout_valid  output  1  one-cycle pulse: new word on dout
parity_err  output  1  parity result of last completed frame
busy  output  1  high while in DATA or PARITY state
frame_cnt  output  8  count of completed frames, good or bad

Behaviour:
- Reset (sync, active-high, priority over bit_en):
  - state=HUNT; sync window=0; fill count=0; bit counter=0.
  - dout=0, dout_valid=0, parity_err=0, busy=0, frame_cnt=0.
- All outputs registered; busy = (state != HUNT), registered with state.
- Edges with bit_en=0: no state, window, counter or data change; dout_valid forced 0.
- HUNT:
  - On each qualified bit: window <= {window[SYNC_W-2:0], si}; fill count saturates at SYNC_W.
  - Match only when fill count (after the update) = SYNC_W and the updated window = SYNC_PAT.
  - This prevents a false match on the reset-cleared window when SYNC_PAT has leading zeros.
  - Sliding window: overlapping prefixes are found (e.g. 1,0,1,0,1,1 matches on the 6th bit).
  - On match: go to DATA, bit counter=0, payload shift reg=0.
- DATA:
  - Each qualified bit: shreg <= {shreg[DATA_W-2:0], si}; counter++.
  - On the DATA_W-th bit go to PARITY.
  - Payload bits are never examined for sync.
- PARITY:
  - Next qualified bit is p.
  - x = XOR of all payload bits XOR p.
  - Error if x=1 (even mode) or x=0 (odd mode).
  - On that same edge:
    - dout <= payload; parity_err <= error; dout_valid <= 1.
    - frame_cnt <= frame_cnt+1, wrapping 255 -> 0.
    - state <= HUNT; window and fill count cleared.
- Latency: dout_valid is high in exactly the one clock cycle following the edge that sampled p. The next edge clears it regardless of bit_en.
- dout and parity_err hold their values until the next completed frame. An errored frame still updates dout.
- Back-to-back frames: a new sync may begin on the first qualified bit after p. Minimum frame length is SYNC_W+DATA_W+1 qualified bits.
- Reset mid-frame: the frame is abandoned with no dout_valid, all state is cleared, and hunting restarts after rst deasserts.
- si is ignored while rst=1.

Test Plan:
- Basic frame: after reset, bit_en=1, serial 1,0,1,1 then 0xA5 MSB-first then p=0 -> after the p edge, dout=0xA5, dout_valid=1 for exactly 1 cycle, parity_err=0, frame_cnt=1, busy returns to 0.
- Parity error: same stream with p=1 -> dout=0xA5, dout_valid pulse, parity_err=1, frame_cnt=1. Set PARITY_ODD=1 with p=1 -> parity_err=0.
- Sliding sync / no payload sync: 1,0,1,0,1,1 then 0xBB (contains 1011) then p=0 -> exactly one frame decoded, dout=0xBB, busy high throughout the 9 payload+parity bits.
- bit_en gaps: same stream as the basic frame with bit_en alternating 1/0 and si garbage while bit_en=0 -> identical result, dout_valid still a single cycle.
- Reset mid-frame: rst pulsed for 1 cycle after 3 payload bits -> busy=0, dout=0, frame_cnt=0, no dout_valid. A following full frame of 0x3C, p=0 -> dout=0x3C, frame_cnt=1.
- Wrap and back-to-back: 256 consecutive frames with no idle bits -> 256 dout_valid pulses and frame_cnt ends at 0. One more frame -> frame_cnt=1.
